// File: rtl/chip8_frame_streamer.sv
// CHIP-8 framebuffer streamer: snapshots the 64x32 display on request
// and serialises it as 256 MSB-leftmost pixel bytes over valid/ready.
module chip8_frame_streamer #(
    parameter int AUTO_PERIOD = 0,
    parameter int PERIOD_W    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2047:0] display,
    input  logic          start_frame,
    output logic [7:0]    tdata,
    output logic          tvalid,
    input  logic          tready,
    output logic          tfirst,
    output logic          tlast,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [PERIOD_W-1:0] WRAP = PERIOD_W'(AUTO_PERIOD - 1);

    state_t              state;
    logic [2047:0]       snap;
    logic [7:0]          idx;
    logic [PERIOD_W-1:0] cnt;
    logic                tick;
    logic                req;
    logic                last_hs;

    // Byte k is 8 pixels starting at bit 8k; lowest x lands in bit 7.
    function automatic logic [7:0] pick(input logic [2047:0] v,
                                        input logic [7:0]    k);
        logic [7:0]  b;
        logic [10:0] pos;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            pos = {k, 3'(j)};
            b[3'(7 - j)] = v[pos];
        end
        return b;
    endfunction

    assign tick    = (AUTO_PERIOD != 0) && (cnt == WRAP);
    assign req     = start_frame || tick;
    assign last_hs = tready && (idx == 8'd255);

    always_ff @(posedge clk) begin
        if (reset || AUTO_PERIOD == 0) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            snap       <= '0;
            idx        <= '0;
            tdata      <= '0;
            tvalid     <= 1'b0;
            tfirst     <= 1'b0;
            tlast      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        snap   <= display;
                        idx    <= '0;
                        tdata  <= pick(display, 8'd0);
                        tvalid <= 1'b1;
                        tfirst <= 1'b1;
                        tlast  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    // The snapshot is held, so any request here is lost.
                    overrun <= req;
                    if (last_hs) begin
                        tdata      <= '0;
                        tvalid     <= 1'b0;
                        tfirst     <= 1'b0;
                        tlast      <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else if (tready) begin
                        idx    <= idx + 8'd1;
                        tdata  <= pick(snap, idx + 8'd1);
                        tfirst <= 1'b0;
                        tlast  <= (idx == 8'd254);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_frame_streamer.sv
// Directed bench for chip8_frame_streamer: frame contents, backpressure,
// snapshot isolation, overrun, reset abort and auto-period triggering.
module tb_chip8_frame_streamer;

    logic          clk = 1'b0;
    logic          reset;
    logic [2047:0] display;
    logic          start_frame;
    logic [7:0]    tdata;
    logic          tvalid, tready, tfirst, tlast;
    logic          busy, frame_done, overrun;

    logic          reset_a;
    logic [7:0]    a3_tdata, a1_tdata;
    logic          a3_tvalid, a3_tfirst, a3_tlast, a3_busy, a3_done, a3_ovr;
    logic          a1_tvalid, a1_tfirst, a1_tlast, a1_busy, a1_done, a1_ovr;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_b [256];

    always #5 clk = ~clk;

    chip8_frame_streamer #(.AUTO_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .display(display),
        .start_frame(start_frame), .tdata(tdata), .tvalid(tvalid),
        .tready(tready), .tfirst(tfirst), .tlast(tlast), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    chip8_frame_streamer #(.AUTO_PERIOD(300)) u_a300 (
        .clk(clk), .reset(reset_a), .display('0),
        .start_frame(1'b0), .tdata(a3_tdata), .tvalid(a3_tvalid),
        .tready(1'b1), .tfirst(a3_tfirst), .tlast(a3_tlast),
        .busy(a3_busy), .frame_done(a3_done), .overrun(a3_ovr)
    );

    chip8_frame_streamer #(.AUTO_PERIOD(100)) u_a100 (
        .clk(clk), .reset(reset_a), .display('0),
        .start_frame(1'b0), .tdata(a1_tdata), .tvalid(a1_tvalid),
        .tready(1'b1), .tfirst(a1_tfirst), .tlast(a1_tlast),
        .busy(a1_busy), .frame_done(a1_done), .overrun(a1_ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tfirst"}, tfirst, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    function automatic logic [2047:0] checker_disp();
        logic [2047:0] v;
        for (int i = 0; i < 2048; i++) v[i] = ((i % 64) + (i / 64)) % 2 == 1;
        return v;
    endfunction

    task automatic exp_checker();
        for (int k = 0; k < 256; k++)
            exp_b[k] = ((k / 8) % 2 == 1) ? 8'hAA : 8'h55;
    endtask

    task automatic exp_zero();
        for (int k = 0; k < 256; k++) exp_b[k] = 8'h00;
    endtask

    // Called on a falling edge. issue=0 means start_frame was already
    // raised by the previous call; chain=1 raises it in frame_done cycle.
    task automatic run_frame(input string tag, input bit issue,
                             input bit bp, input int toggle_at,
                             input int req_at, input int reset_at,
                             input bit chain);
        int k = 0;
        int cyc = 0;
        int ovr = 0;
        bit stalled = 0;
        bit toggled = 0;
        bit reqd = 0;
        logic [7:0] pd;
        logic pf, pl;
        if (issue) start_frame = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        check({tag, "_start_busy"}, busy, 1);
        check({tag, "_start_tfirst"}, tfirst, 1);
        while (k < 256 && cyc < 3000) begin
            if (reqd) start_frame = 1'b0;
            if (overrun) ovr++;
            check({tag, "_tvalid"}, tvalid, 1);
            if (stalled) begin
                check({tag, "_stall_tdata"}, tdata, pd);
                check({tag, "_stall_tfirst"}, tfirst, pf);
                check({tag, "_stall_tlast"}, tlast, pl);
            end
            if (k == toggle_at && !toggled) begin
                display = ~display;
                toggled = 1'b1;
            end
            if (k == req_at && !reqd) begin
                start_frame = 1'b1;
                reqd = 1'b1;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                check_all_zero({tag, "_rst"});
                reset = 1'b0;
                return;
            end
            tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tready) begin
                check({tag, "_tdata"}, tdata, exp_b[k]);
                check({tag, "_tfirst"}, tfirst, k == 0);
                check({tag, "_tlast"}, tlast, k == 255);
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pd = tdata;
                pf = tfirst;
                pl = tlast;
            end
            @(negedge clk);
            cyc++;
        end
        start_frame = 1'b0;
        check({tag, "_timeout"}, k, 256);
        if (overrun) ovr++;
        check({tag, "_end_tvalid"}, tvalid, 0);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_tlast"}, tlast, 0);
        check({tag, "_frame_done"}, frame_done, 1);
        check({tag, "_overruns"}, ovr, (req_at >= 0) ? 1 : 0);
        if (!bp) check({tag, "_cycles"}, cyc, 256);
        if (chain) begin
            start_frame = 1'b1;
            return;
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, frame_done, 0);
        check({tag, "_no_extra"}, tvalid, 0);
    endtask

    initial begin
        int t3 [2];
        int t1 [2];
        int n3, n1, o3, o1;
        reset = 1'b1;
        reset_a = 1'b1;
        display = '0;
        start_frame = 1'b0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check({"idle_tvalid"}, tvalid, 0);

        display = checker_disp();
        exp_checker();
        run_frame("checker", 1, 0, -1, -1, -1, 0);

        display = '0;
        display[2047] = 1'b1;
        exp_zero();
        exp_b[255] = 8'h01;
        run_frame("px63_31", 1, 0, -1, -1, -1, 0);

        display = '0;
        display[0] = 1'b1;
        exp_zero();
        exp_b[0] = 8'h80;
        run_frame("px0_0", 1, 0, -1, -1, -1, 0);

        display = checker_disp();
        exp_checker();
        run_frame("backpress", 1, 1, -1, -1, -1, 0);

        display = checker_disp();
        run_frame("snap_ovr", 1, 0, 10, 20, -1, 0);

        display = checker_disp();
        run_frame("last_ovr", 1, 0, -1, 255, -1, 1);
        run_frame("chained", 0, 0, -1, -1, -1, 0);

        run_frame("abort", 1, 0, -1, -1, 100, 0);
        @(negedge clk);
        check("abort_no_done", frame_done, 0);
        display = '0;
        display[0] = 1'b1;
        exp_zero();
        exp_b[0] = 8'h80;
        run_frame("after_rst", 1, 0, -1, -1, -1, 0);

        reset_a = 1'b0;
        n3 = 0; n1 = 0; o3 = 0; o1 = 0;
        t3[0] = 0; t3[1] = 0; t1[0] = 0; t1[1] = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (a3_ovr) o3++;
            if (a1_ovr && n1 == 1) o1++;
            if (a3_tvalid && a3_tfirst && n3 < 2) begin
                t3[n3] = c;
                n3++;
            end
            if (a1_tvalid && a1_tfirst && n1 < 2) begin
                t1[n1] = c;
                n1++;
            end
        end
        check("auto300_frames", n3, 2);
        check("auto300_gap", t3[1] - t3[0], 300);
        check("auto300_ovr", o3, 0);
        check("auto100_frames", n1, 2);
        check("auto100_gap", t1[1] - t1[0], 300);
        check("auto100_ovr", o1, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
